sprite_blitter: RTL and testbench

Copy engine that reads a rectangular sprite out of a combinational sprite ROM and writes its opaque pixels into the 640x480 frame buffer at a signed screen position. It is the consumer side of the sprite ROMs: it drives their read address, takes the palette-resolved 12-bit color back, drops the transparency key color and clips against the screen edges. It sits between the game-logic sprite scheduler (which issues `start`) and the frame-buffer write port.

---
 rtl/sprite_pkg.sv | 41 ++++
 rtl/blit_clip.sv | 30 +++
 rtl/sprite_blitter.sv | 198 +++++++++++++++++++
 tb/tb_sprite_blitter.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared sprite definitions: screen geometry, color type, blitter state
// encoding and a constant-coefficient row-scaling helper.
package sprite_pkg;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [11:0] color_t;

    localparam color_t TRANSPARENT = 12'h808;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } blit_state_t;

    // Signed frame-buffer row base: holds py*SCREEN_W for py in [-1024, 2047].
    localparam int ROW_BASE_W = 23;
    typedef logic signed [ROW_BASE_W-1:0] row_base_t;

    // Scales a screen y by a constant width with shift-and-add only; the
    // width argument is a constant so this folds into a few adders.
    function automatic row_base_t scale_row(input logic signed [10:0] y,
                                            input int unsigned     k);
        row_base_t acc;
        row_base_t y_ext;
        acc   = '0;
        y_ext = {{12{y[10]}}, y};
        for (int i = 0; i < 11; i++) begin
            if (k[i]) begin
                acc = acc + (y_ext <<< i);
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/blit_clip.sv
// Combinational screen clipper: turns the current sprite pixel position into
// an on-screen flag and its frame-buffer address (row base + x).
module blit_clip #(
    parameter int unsigned SCREEN_W = sprite_pkg::SCREEN_W,
    parameter int unsigned SCREEN_H = sprite_pkg::SCREEN_H,
    parameter int unsigned FB_AW    = 19
) (
    input  logic signed [10:0]    dst_x,
    input  logic signed [10:0]    dst_y,
    input  logic [9:0]            col,
    input  logic [9:0]            row,
    input  sprite_pkg::row_base_t row_base,
    output logic                  on_screen,
    output logic [FB_AW-1:0]      fb_addr
);
    import sprite_pkg::*;

    logic signed [11:0] px_s;
    logic signed [11:0] py_s;

    // Pixel coordinates, range test against both screen edges, and address.
    always_comb begin
        px_s      = $signed({dst_x[10], dst_x}) + $signed({2'b00, col});
        py_s      = $signed({dst_y[10], dst_y}) + $signed({2'b00, row});
        on_screen = !px_s[11] && ({1'b0, px_s[10:0]} < 12'(SCREEN_W)) &&
                    !py_s[11] && ({1'b0, py_s[10:0]} < 12'(SCREEN_H));
        fb_addr   = FB_AW'(row_base + {{11{px_s[11]}}, px_s});
    end

endmodule

// File: rtl/sprite_blitter.sv
// Sprite copy engine: walks a row-major sprite in ROM one pixel per advance,
// drops the transparency key, clips to the screen and drives a held-until-
// accepted frame-buffer write port.
module sprite_blitter #(
    parameter int unsigned       SCREEN_W    = sprite_pkg::SCREEN_W,
    parameter int unsigned       SCREEN_H    = sprite_pkg::SCREEN_H,
    parameter int unsigned       ROM_AW      = 18,
    parameter int unsigned       FB_AW       = 19,
    parameter sprite_pkg::color_t TRANSPARENT = sprite_pkg::TRANSPARENT
) (
    input  logic                Clk,
    input  logic                Reset_n,
    input  logic                start,
    input  logic [ROM_AW-1:0]   src_base,
    input  logic [9:0]          spr_w,
    input  logic [9:0]          spr_h,
    input  logic signed [10:0]  dst_x,
    input  logic signed [10:0]  dst_y,
    output logic                busy,
    output logic                done,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [11:0]         rom_color,
    output logic [FB_AW-1:0]    fb_addr,
    output logic [11:0]         fb_data,
    output logic                fb_we,
    input  logic                fb_ready
);
    import sprite_pkg::*;

    blit_state_t        state_r,    state_nxt_s;
    logic [9:0]         w_r,        w_nxt_s;
    logic [9:0]         h_r,        h_nxt_s;
    logic signed [10:0] dx_r,       dx_nxt_s;
    logic signed [10:0] dy_r,       dy_nxt_s;
    logic [9:0]         col_r,      col_nxt_s;
    logic [9:0]         row_r,      row_nxt_s;
    logic [ROM_AW-1:0]  ptr_r,      ptr_nxt_s;
    row_base_t          rb_r,       rb_nxt_s;
    logic               fb_we_r,    fb_we_nxt_s;
    logic [FB_AW-1:0]   fb_addr_r,  fb_addr_nxt_s;
    logic [11:0]        fb_data_r,  fb_data_nxt_s;
    logic               busy_r;
    logic               done_r;

    logic               advance_s;
    logic               last_col_s;
    logic               last_row_s;
    logic               on_screen_s;
    logic [FB_AW-1:0]   pix_addr_s;

    blit_clip #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H),
        .FB_AW    (FB_AW)
    ) u_clip (
        .dst_x     (dx_r),
        .dst_y     (dy_r),
        .col       (col_r),
        .row       (row_r),
        .row_base  (rb_r),
        .on_screen (on_screen_s),
        .fb_addr   (pix_addr_s)
    );

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state plus next values of counters, pointer and write port.
    always_comb begin
        state_nxt_s   = state_r;
        w_nxt_s       = w_r;
        h_nxt_s       = h_r;
        dx_nxt_s      = dx_r;
        dy_nxt_s      = dy_r;
        col_nxt_s     = col_r;
        row_nxt_s     = row_r;
        ptr_nxt_s     = ptr_r;
        rb_nxt_s      = rb_r;
        fb_we_nxt_s   = fb_we_r;
        fb_addr_nxt_s = fb_addr_r;
        fb_data_nxt_s = fb_data_r;

        // A pending write blocks progress until the frame buffer takes it.
        advance_s  = !fb_we_r || fb_ready;
        last_col_s = (col_r == (w_r - 10'd1));
        last_row_s = (row_r == (h_r - 10'd1));

        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    w_nxt_s   = spr_w;
                    h_nxt_s   = spr_h;
                    dx_nxt_s  = dst_x;
                    dy_nxt_s  = dst_y;
                    col_nxt_s = 10'd0;
                    row_nxt_s = 10'd0;
                    ptr_nxt_s = src_base;
                    rb_nxt_s  = scale_row(dst_y, SCREEN_W);
                    if ((spr_w == 10'd0) || (spr_h == 10'd0)) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (advance_s) begin
                    if ((rom_color != TRANSPARENT) && on_screen_s) begin
                        fb_we_nxt_s   = 1'b1;
                        fb_addr_nxt_s = pix_addr_s;
                        fb_data_nxt_s = rom_color;
                    end else begin
                        fb_we_nxt_s   = 1'b0;
                    end
                    ptr_nxt_s = ptr_r + ROM_AW'(1);
                    if (last_col_s) begin
                        col_nxt_s = 10'd0;
                        row_nxt_s = row_r + 10'd1;
                        rb_nxt_s  = rb_r + row_base_t'(SCREEN_W);
                    end else begin
                        col_nxt_s = col_r + 10'd1;
                    end
                    if (last_col_s && last_row_s) begin
                        state_nxt_s = ST_DRAIN;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (advance_s) begin
                    fb_we_nxt_s = 1'b0;
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                fb_we_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath and output registers; reset drops any pending write.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            w_r       <= 10'd0;
            h_r       <= 10'd0;
            dx_r      <= 11'sd0;
            dy_r      <= 11'sd0;
            col_r     <= 10'd0;
            row_r     <= 10'd0;
            ptr_r     <= '0;
            rb_r      <= '0;
            fb_we_r   <= 1'b0;
            fb_addr_r <= '0;
            fb_data_r <= 12'h000;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            w_r       <= w_nxt_s;
            h_r       <= h_nxt_s;
            dx_r      <= dx_nxt_s;
            dy_r      <= dy_nxt_s;
            col_r     <= col_nxt_s;
            row_r     <= row_nxt_s;
            ptr_r     <= ptr_nxt_s;
            rb_r      <= rb_nxt_s;
            fb_we_r   <= fb_we_nxt_s;
            fb_addr_r <= fb_addr_nxt_s;
            fb_data_r <= fb_data_nxt_s;
            busy_r    <= (state_nxt_s != ST_IDLE);
            done_r    <= (state_nxt_s == ST_DONE);
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign rom_addr = ptr_r;
    assign fb_we    = fb_we_r;
    assign fb_addr  = fb_addr_r;
    assign fb_data  = fb_data_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed self-checking bench for sprite_blitter with a small ROM model and
// a write monitor that records every accepted frame-buffer write.
module tb_sprite_blitter;

    logic               Clk;
    logic               Reset_n;
    logic               start;
    logic [17:0]        src_base;
    logic [9:0]         spr_w;
    logic [9:0]         spr_h;
    logic signed [10:0] dst_x;
    logic signed [10:0] dst_y;
    logic               busy;
    logic               done;
    logic [17:0]        rom_addr;
    logic [11:0]        rom_color;
    logic [18:0]        fb_addr;
    logic [11:0]        fb_data;
    logic               fb_we;
    logic               fb_ready;

    logic [11:0] rom_mem [0:63];
    logic [18:0] wa_q [$];
    logic [11:0] wd_q [$];
    int          wc_q [$];
    int          cyc;
    int          c0;
    int          done_rel;
    int          n_checks;
    int          n_pass;

    sprite_blitter dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .start     (start),
        .src_base  (src_base),
        .spr_w     (spr_w),
        .spr_h     (spr_h),
        .dst_x     (dst_x),
        .dst_y     (dst_y),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_color (rom_color),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_we     (fb_we),
        .fb_ready  (fb_ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign rom_color = (rom_addr < 18'd64) ? rom_mem[rom_addr[5:0]] : 12'h000;

    // Cycle counter: value during a cycle is that cycle's index.
    always @(posedge Clk) cyc <= cyc + 1;

    // Record accepted writes mid-cycle.
    always @(negedge Clk) begin
        if (Reset_n && fb_we && fb_ready) begin
            wa_q.push_back(fb_addr);
            wd_q.push_back(fb_data);
            wc_q.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic start_blit(input logic [17:0] base, input logic [9:0] w, input logic [9:0] h,
                              input logic signed [10:0] x, input logic signed [10:0] y);
        @(posedge Clk); #1;
        src_base = base; spr_w = w; spr_h = h; dst_x = x; dst_y = y;
        start = 1'b1;
        c0 = cyc;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        @(posedge Clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit got;
        got = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge Clk);
            if (done === 1'b1) begin
                done_rel = cyc - c0;
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            done_rel = -1;
            check_eq({tag, " done timeout"}, 32'd0, 32'd1);
        end
    endtask

    task automatic check_4x2(input string tag, input int base);
        check_eq({tag, " nwr"}, wa_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("%s addr%0d", tag, i), wa_q[i], (i < 4) ? 3210 + i : 3850 + i - 4);
            check_eq($sformatf("%s data%0d", tag, i), wd_q[i], rom_mem[base + i]);
            check_eq($sformatf("%s cyc%0d", tag, i), wc_q[i] - c0, 2 + i);
        end
        check_eq({tag, " done cyc"}, done_rel, 10);
    endtask

    initial begin
        n_checks = 0; n_pass = 0; cyc = 0; c0 = 0; done_rel = 0;
        Reset_n = 1'b0; start = 1'b0; fb_ready = 1'b1;
        src_base = 18'd0; spr_w = 10'd0; spr_h = 10'd0; dst_x = 11'sd0; dst_y = 11'sd0;
        for (int i = 0; i < 64; i++) rom_mem[i] = 12'h100 + 12'(i);
        rom_mem[17] = 12'h808; rom_mem[19] = 12'h808;
        rom_mem[21] = 12'h808; rom_mem[23] = 12'h808;

        // Reset state
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_eq("rst busy", busy, 0);
        check_eq("rst done", done, 0);
        check_eq("rst fb_we", fb_we, 0);
        check_eq("rst fb_addr", fb_addr, 0);
        check_eq("rst fb_data", fb_data, 0);
        check_eq("rst rom_addr", rom_addr, 0);
        @(posedge Clk); #1;
        Reset_n = 1'b1;

        // 4x2 opaque sprite at (10,5)
        start_blit(18'd0, 10'd4, 10'd2, 11'sd10, 11'sd5);
        wait_done("t1");
        check_4x2("t1", 0);

        // Same shape with transparent key at cols 1 and 3
        start_blit(18'd16, 10'd4, 10'd2, 11'sd10, 11'sd5);
        wait_done("t2");
        check_eq("t2 nwr", wa_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t2 addr%0d", i), wa_q[i], (i < 2) ? 3210 + 2 * i : 3850 + 2 * (i - 2));
            check_eq($sformatf("t2 data%0d", i), wd_q[i], rom_mem[16 + 2 * i]);
            check_eq($sformatf("t2 cyc%0d", i), wc_q[i] - c0, 2 + 2 * i);
        end
        check_eq("t2 done cyc", done_rel, 10);

        // Left-edge clip
        start_blit(18'd32, 10'd4, 10'd1, -11'sd2, 11'sd0);
        wait_done("t3a");
        check_eq("t3a nwr", wa_q.size(), 2);
        check_eq("t3a addr0", wa_q[0], 0);
        check_eq("t3a addr1", wa_q[1], 1);
        check_eq("t3a data0", wd_q[0], rom_mem[34]);
        check_eq("t3a data1", wd_q[1], rom_mem[35]);

        // Right/bottom-edge clip
        start_blit(18'd32, 10'd4, 10'd1, 11'sd638, 11'sd479);
        wait_done("t3b");
        check_eq("t3b nwr", wa_q.size(), 2);
        check_eq("t3b addr0", wa_q[0], 307198);
        check_eq("t3b addr1", wa_q[1], 307199);
        check_eq("t3b data0", wd_q[0], rom_mem[32]);
        check_eq("t3b data1", wd_q[1], rom_mem[33]);

        // Back-pressure: fb_ready low for 3 cycles after first fb_we
        start_blit(18'd40, 10'd3, 10'd1, 11'sd0, 11'sd0);
        @(posedge Clk); #1;
        fb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check_eq($sformatf("t4 we%0d", i), fb_we, 1);
            check_eq($sformatf("t4 addr%0d", i), fb_addr, 0);
            check_eq($sformatf("t4 data%0d", i), fb_data, rom_mem[40]);
            check_eq($sformatf("t4 rom%0d", i), rom_addr, 41);
            @(posedge Clk); #1;
        end
        fb_ready = 1'b1;
        wait_done("t4");
        check_eq("t4 nwr", wa_q.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("t4 wa%0d", i), wa_q[i], i);
            check_eq($sformatf("t4 wd%0d", i), wd_q[i], rom_mem[40 + i]);
        end
        check_eq("t4 done cyc", done_rel, 8);

        // Zero width: done in cycle 1; start held during done is ignored
        @(posedge Clk); #1;
        src_base = 18'd0; spr_w = 10'd0; spr_h = 10'd3; dst_x = 11'sd0; dst_y = 11'sd0;
        start = 1'b1; c0 = cyc;
        wa_q.delete(); wd_q.delete(); wc_q.delete();
        @(posedge Clk); #1;
        @(negedge Clk);
        check_eq("t5 done c1", done, 1);
        check_eq("t5 busy c1", busy, 1);
        @(posedge Clk); #1;
        start = 1'b0;
        @(negedge Clk);
        check_eq("t5 busy c2", busy, 0);
        check_eq("t5 done c2", done, 0);
        check_eq("t5 nwr", wa_q.size(), 0);

        // Long 8x4 blit with a second start pulsed mid-way
        start_blit(18'd24, 10'd8, 10'd4, 11'sd0, 11'sd0);
        repeat (8) @(posedge Clk);
        #1;
        src_base = 18'd0; spr_w = 10'd2; spr_h = 10'd2; dst_x = 11'sd100; dst_y = 11'sd100;
        start = 1'b1;
        @(posedge Clk); #1;
        start = 1'b0;
        wait_done("t6");
        check_eq("t6 nwr", wa_q.size(), 32);
        check_eq("t6 first", wa_q[0], 0);
        check_eq("t6 last", wa_q[31], 1927);
        check_eq("t6 lastd", wd_q[31], rom_mem[55]);
        check_eq("t6 done cyc", done_rel, 34);
        @(posedge Clk); #1;
        @(negedge Clk);
        check_eq("t6 idle", busy, 0);

        // Reset for one cycle mid-RUN, then a full blit
        start_blit(18'd24, 10'd8, 10'd4, 11'sd0, 11'sd0);
        repeat (4) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(negedge Clk);
        check_eq("t7 busy", busy, 0);
        check_eq("t7 fb_we", fb_we, 0);
        start_blit(18'd0, 10'd4, 10'd2, 11'sd10, 11'sd5);
        wait_done("t7");
        check_4x2("t7", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
